// File: rtl/resta_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the controller state encoding used by resta_serial.
package resta_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIN  = 2'd2
    } resta_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when a borrow is taken.
// Latency: combinational.
// Backpressure: none, pure logic.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/resta_serial.sv
// Bit-serial N-bit subtractor (answer = minuend - subtrahend mod 2^N), LSB first.
// Latency: N busy cycles after start is accepted, then a one-cycle done pulse.
// Backpressure: start is only honoured in IDLE; requests while busy/FIN are dropped.
module resta_serial
    import resta_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] minuend,
    input  logic [N-1:0] subtrahend,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] answer,
    output logic         borrow_out,
    output logic         overflow,
    output logic         zero
);

    localparam int CW = $clog2(N) + 1;

    resta_state_t  state;
    resta_state_t  state_nxt;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  res_sh;
    logic [N-1:0]  res_nxt;
    logic [CW-1:0] cnt;
    logic          borrow_reg;
    logic          fs_d;
    logic          fs_bout;
    logic          last_bit;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow_reg),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign last_bit = (cnt == CW'(N - 1));
    assign res_nxt  = {fs_d, res_sh[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SUB;
                end
            end
            SUB: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            cnt        <= '0;
            borrow_reg <= 1'b0;
            answer     <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh       <= minuend;
                        b_sh       <= subtrahend;
                        res_sh     <= '0;
                        cnt        <= '0;
                        borrow_reg <= 1'b0;
                    end
                end
                SUB: begin
                    a_sh       <= a_sh >> 1;
                    b_sh       <= b_sh >> 1;
                    res_sh     <= res_nxt;
                    borrow_reg <= fs_bout;
                    if (!last_bit) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        // On the last bit a_sh[0]/b_sh[0] are the operand sign bits.
                        answer     <= res_nxt;
                        borrow_out <= fs_bout;
                        overflow   <= (a_sh[0] ^ b_sh[0]) & (fs_d ^ a_sh[0]);
                        zero       <= ~|res_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_resta_serial.sv
// Directed bench for resta_serial: N=4 vector table, mid-operation corner cases, N=8 back-to-back.
module tb_resta_serial;

    logic       clk;
    logic       rst_n;

    logic       start4;
    logic [3:0] min4;
    logic [3:0] sub4;
    logic       busy4;
    logic       done4;
    logic [3:0] ans4;
    logic       bo4;
    logic       ov4;
    logic       z4;

    logic       start8;
    logic [7:0] min8;
    logic [7:0] sub8;
    logic       busy8;
    logic       done8;
    logic [7:0] ans8;
    logic       bo8;
    logic       ov8;
    logic       z8;

    int n_checks = 0;
    int n_fail   = 0;

    resta_serial #(.N(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .minuend    (min4),
        .subtrahend (sub4),
        .busy       (busy4),
        .done       (done4),
        .answer     (ans4),
        .borrow_out (bo4),
        .overflow   (ov4),
        .zero       (z4)
    );

    resta_serial #(.N(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .minuend    (min8),
        .subtrahend (sub8),
        .busy       (busy8),
        .done       (done8),
        .answer     (ans8),
        .borrow_out (bo8),
        .overflow   (ov8),
        .zero       (z8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] ans;
        logic       bo;
        logic       ov;
        logic       z;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Starts one operation, scrambles the operand inputs after capture, then
    // waits (bounded) for done; returns at the negedge where done is seen.
    task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                          output int bc, output bit gd);
        @(negedge clk);
        if (w8) begin
            min8   = a;
            sub8   = b;
            start8 = 1'b1;
        end else begin
            min4   = a[3:0];
            sub4   = b[3:0];
            start4 = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        min4   = ~min4;
        sub4   = ~sub4;
        min8   = ~min8;
        sub8   = ~sub8;
        bc = 0;
        gd = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (w8 ? done8 : done4) begin
                gd = 1'b1;
                break;
            end
            if (w8 ? busy8 : busy4) bc++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bc;
        bit  gd;
        int  seen;

        // 9-3 and 3-9 cross the signed range, so overflow is set for both.
        vecs[0] = '{a: 4'd9, b: 4'd3, ans: 4'd6,    bo: 1'b0, ov: 1'b1, z: 1'b0};
        vecs[1] = '{a: 4'd3, b: 4'd9, ans: 4'b1010, bo: 1'b1, ov: 1'b1, z: 1'b0};
        vecs[2] = '{a: 4'd5, b: 4'd5, ans: 4'd0,    bo: 1'b0, ov: 1'b0, z: 1'b1};
        vecs[3] = '{a: 4'd7, b: 4'd8, ans: 4'b1111, bo: 1'b1, ov: 1'b1, z: 1'b0};
        vecs[4] = '{a: 4'd8, b: 4'd1, ans: 4'd7,    bo: 1'b0, ov: 1'b1, z: 1'b0};
        vecs[5] = '{a: 4'd4, b: 4'd2, ans: 4'd2,    bo: 1'b0, ov: 1'b0, z: 1'b0};

        rst_n  = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;
        min4   = 4'hF;
        sub4   = 4'hF;
        min8   = 8'hFF;
        sub8   = 8'hFF;
        #1;
        chk("reset busy", 32'(busy4), 32'd0);
        chk("reset done", 32'(done4), 32'd0);
        chk("reset answer", 32'(ans4), 32'd0);
        chk("reset flags", 32'({bo4, ov4, z4}), 32'd0);
        chk("reset n8 outputs", 32'({busy8, done8, ans8, bo8, ov8, z8}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_op(1'b0, {4'd0, vecs[v].a}, {4'd0, vecs[v].b}, bc, gd);
            chk($sformatf("v%0d done seen", v), 32'(gd), 32'd1);
            chk($sformatf("v%0d busy cycles", v), 32'(bc), 32'd4);
            chk($sformatf("v%0d answer", v), 32'(ans4), 32'(vecs[v].ans));
            chk($sformatf("v%0d borrow_out", v), 32'(bo4), 32'(vecs[v].bo));
            chk($sformatf("v%0d overflow", v), 32'(ov4), 32'(vecs[v].ov));
            chk($sformatf("v%0d zero", v), 32'(z4), 32'(vecs[v].z));
            @(negedge clk);
            chk($sformatf("v%0d done one cycle", v), 32'({done4, busy4}), 32'd0);
            chk($sformatf("v%0d answer held", v), 32'(ans4), 32'(vecs[v].ans));
        end

        // Second start during SUB is dropped and not queued.
        @(negedge clk);
        min4   = 4'd9;
        sub4   = 4'd3;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        min4   = 4'd1;
        sub4   = 4'd1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        gd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done4) begin
                gd = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ignore done seen", 32'(gd), 32'd1);
        chk("ignore answer", 32'(ans4), 32'd6);
        chk("ignore overflow", 32'(ov4), 32'd1);
        repeat (4) @(negedge clk);
        chk("ignore no queued op", 32'(busy4), 32'd0);
        chk("ignore answer held", 32'(ans4), 32'd6);

        // Reset in the middle of SUB aborts and clears everything at once.
        min4   = 4'd9;
        sub4   = 4'd3;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy4), 32'd0);
        chk("abort done", 32'(done4), 32'd0);
        chk("abort answer", 32'(ans4), 32'd0);
        chk("abort flags", 32'({bo4, ov4, z4}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done4 || busy4) seen++;
        end
        chk("abort no done pulse", 32'(seen), 32'd0);
        run_op(1'b0, 8'd4, 8'd2, bc, gd);
        chk("after abort done seen", 32'(gd), 32'd1);
        chk("after abort answer", 32'(ans4), 32'd2);

        // N=8, then a restart in the IDLE cycle right after FIN.
        run_op(1'b1, 8'd200, 8'd1, bc, gd);
        chk("n8 done seen", 32'(gd), 32'd1);
        chk("n8 busy cycles", 32'(bc), 32'd8);
        chk("n8 answer", 32'(ans8), 32'd199);
        chk("n8 borrow_out", 32'(bo8), 32'd0);
        chk("n8 overflow", 32'(ov8), 32'd0);
        run_op(1'b1, 8'd0, 8'd1, bc, gd);
        chk("n8 b2b done seen", 32'(gd), 32'd1);
        chk("n8 b2b busy cycles", 32'(bc), 32'd8);
        chk("n8 b2b answer", 32'(ans8), 32'd255);
        chk("n8 b2b borrow_out", 32'(bo8), 32'd1);
        chk("n8 b2b overflow", 32'(ov8), 32'd0);
        chk("n8 b2b zero", 32'(z8), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
